// File: rtl/hbridge_deadtime_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Package  : hbridge_deadtime_pkg                                  |
// | Purpose  : Shared types and constants for the H-bridge dead-time |
// |            gate-drive stage (leg states, requests, reg map).     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package hbridge_deadtime_pkg;

  // Per-leg gate FSM states
  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_HI   = 2'd1,
    LEG_LO   = 2'd2,
    LEG_DEAD = 2'd3
  } leg_state_t;

  // What the request mapper asks of each leg; 2'd3 is treated as OFF
  typedef enum logic [1:0] {
    REQ_OFF = 2'd0,
    REQ_HI  = 2'd1,
    REQ_LO  = 2'd2
  } leg_req_t;

  // Register map
  localparam logic ADDR_DT   = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Control register bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

endpackage
`default_nettype wire

// File: rtl/hbridge_deadtime_leg.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : leg_deadtime                                          |
// | Purpose  : One H-bridge leg: OFF/HI/LO/DEAD FSM with a dead-time |
// |            counter so high and low switches never overlap.       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module leg_deadtime
  import hbridge_deadtime_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [DT_W-1:0] dt,
  output logic            hi,
  output logic            lo
);

  leg_state_t      state, state_nxt;
  logic [DT_W-1:0] cnt, cnt_nxt;
  logic            req_on;

  // Anything other than HI/LO (including the spare code) means "off"
  assign req_on = (req == REQ_HI) || (req == REQ_LO);

  // State, counter and gate flops; gates are decoded from the next state
  // so they come straight out of a flop with no decode glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LEG_OFF;
      cnt   <= '0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= (state_nxt == LEG_HI);
      lo    <= (state_nxt == LEG_LO);
    end
  end

  // Next-state logic: every turn-on passes through DEAD, turn-off is immediate
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LEG_OFF: begin
        if (req_on) begin
          state_nxt = LEG_DEAD;
          cnt_nxt   = dt;
        end
      end
      LEG_HI: begin
        if (!req_on) begin
          state_nxt = LEG_OFF;
        end else if (req == REQ_LO) begin
          state_nxt = LEG_DEAD;
          cnt_nxt   = dt;
        end
      end
      LEG_LO: begin
        if (!req_on) begin
          state_nxt = LEG_OFF;
        end else if (req == REQ_HI) begin
          state_nxt = LEG_DEAD;
          cnt_nxt   = dt;
        end
      end
      LEG_DEAD: begin
        if (!req_on) begin
          state_nxt = LEG_OFF;
          cnt_nxt   = '0;
        end else if (cnt <= DT_W'(1)) begin
          // Resolve to whatever is requested now, so a pulse shorter than
          // the dead time simply returns to the original switch.
          state_nxt = (req == REQ_HI) ? LEG_HI : LEG_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - DT_W'(1);
        end
      end
      default: begin
        state_nxt = LEG_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hbridge_deadtime.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : hbridge_deadtime                                      |
// | Purpose  : Gate-drive stage after the PWM generator: registers,  |
// |            fault synchronizer/latch, leg request mapping and two |
// |            dead-time leg FSMs.                                   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module hbridge_deadtime
  import hbridge_deadtime_pkg::*;
#(
  parameter int              DT_W     = 8,
  parameter logic [DT_W-1:0] DT_RESET = DT_W'(20)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_n,
  input  logic        addr,
  input  logic [31:0] wrdata,
  input  logic        pwm_in,
  input  logic        dir_in,
  input  logic        fault_in,
  output logic        hi_a,
  output logic        lo_a,
  output logic        hi_b,
  output logic        lo_b,
  output logic        fault_flag
);

  logic [DT_W-1:0] dt;
  logic            enable;
  logic            clr_req;
  logic            pwm_q;
  logic            dir_q;
  logic            fault_s1;
  logic            fault_s2;
  leg_req_t        active_req;
  leg_req_t        req_a;
  leg_req_t        req_b;
  logic            unused_wrdata;

  // Upper write-data bits have no register behind them
  assign unused_wrdata = ^wrdata;

  // Register file; the clear request is held for one cycle so it is
  // judged against the synchronized fault on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dt      <= DT_RESET;
      enable  <= 1'b0;
      clr_req <= 1'b0;
    end else begin
      clr_req <= 1'b0;
      if (!wr_n) begin
        case (addr)
          ADDR_DT: begin
            // Zero dead time is never allowed; clamp to one cycle
            dt <= (wrdata[DT_W-1:0] == '0) ? DT_W'(1) : wrdata[DT_W-1:0];
          end
          ADDR_CTRL: begin
            enable  <= wrdata[CTRL_EN];
            clr_req <= wrdata[CTRL_CLR];
          end
        endcase
      end
    end
  end

  // Input registers, fault synchronizer and sticky fault flag (fault wins over clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q      <= 1'b0;
      dir_q      <= 1'b0;
      fault_s1   <= 1'b0;
      fault_s2   <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
      pwm_q      <= pwm_in;
      dir_q      <= dir_in;
      fault_s1   <= fault_in;
      fault_s2   <= fault_s1;
      fault_flag <= fault_s2 | (fault_flag & ~clr_req);
    end
  end

  // Map PWM/direction onto per-leg requests; passive leg brakes on its low side
  always_comb begin
    active_req = pwm_q ? REQ_HI : REQ_LO;
    req_a      = REQ_OFF;
    req_b      = REQ_OFF;
    if (enable && !fault_flag) begin
      if (!dir_q) begin
        req_a = active_req;
        req_b = REQ_LO;
      end else begin
        req_a = REQ_LO;
        req_b = active_req;
      end
    end
  end

  leg_deadtime #(
    .DT_W (DT_W)
  ) u_leg_a (
    .clk   (clk),
    .reset (reset),
    .req   (req_a),
    .dt    (dt),
    .hi    (hi_a),
    .lo    (lo_a)
  );

  leg_deadtime #(
    .DT_W (DT_W)
  ) u_leg_b (
    .clk   (clk),
    .reset (reset),
    .req   (req_b),
    .dt    (dt),
    .hi    (hi_b),
    .lo    (lo_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_hbridge_deadtime.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : tb_hbridge_deadtime                                   |
// | Purpose  : Directed self-checking bench for hbridge_deadtime.    |
// |            Expected gate vectors {hi_a,lo_a,hi_b,lo_b,flag} are  |
// |            queued as stimulus is driven, popped after each edge. |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_hbridge_deadtime;
  import hbridge_deadtime_pkg::*;

  logic        clk;
  logic        reset;
  logic        wr_n;
  logic        addr;
  logic [31:0] wrdata;
  logic        pwm_in;
  logic        dir_in;
  logic        fault_in;
  logic        hi_a, lo_a, hi_b, lo_b, fault_flag;

  int vectors     = 0;
  int miscompares = 0;

  string      tag_q[$];
  logic [4:0] exp_q[$];

  // Vector layout: {hi_a, lo_a, hi_b, lo_b, fault_flag}
  localparam logic [4:0] ALL_OFF   = 5'b00000;
  localparam logic [4:0] LO_LO     = 5'b01010;
  localparam logic [4:0] DEADA_LOB = 5'b00010;
  localparam logic [4:0] HIA_LOB   = 5'b10010;
  localparam logic [4:0] LOA_HIB   = 5'b01100;
  localparam logic [4:0] LOA_DEADB = 5'b01000;
  localparam logic [4:0] FLT_RUN   = 5'b01101;
  localparam logic [4:0] FLT_OFF   = 5'b00001;

  hbridge_deadtime #(
    .DT_W     (8),
    .DT_RESET (8'd20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_n       (wr_n),
    .addr       (addr),
    .wrdata     (wrdata),
    .pwm_in     (pwm_in),
    .dir_in     (dir_in),
    .fault_in   (fault_in),
    .hi_a       (hi_a),
    .lo_a       (lo_a),
    .hi_b       (hi_b),
    .lo_b       (lo_b),
    .fault_flag (fault_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] gates();
    return {hi_a, lo_a, hi_b, lo_b, fault_flag};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare against the oldest queued expectation
  task automatic tick();
    string      t;
    logic [4:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_underflow: observed %b expected none", gates());
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, gates(), e);
    end
  endtask

  task automatic expect_step(input string tag, input logic [4:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
    tick();
  endtask

  task automatic expect_run(input int n, input string tag, input logic [4:0] e);
    for (int i = 0; i < n; i++) expect_step(tag, e);
  endtask

  task automatic reg_write(input logic a, input logic [31:0] d,
                           input string tag, input logic [4:0] e);
    addr   = a;
    wrdata = d;
    wr_n   = 1'b0;
    expect_step(tag, e);
    wr_n   = 1'b1;
  endtask

  // Same-leg overlap must never appear outside reset
  always @(negedge clk) begin
    if (!reset) begin
      vectors++;
      assert (((hi_a & lo_a) | (hi_b & lo_b)) === 1'b0) else begin
        miscompares++;
        $error("FAIL overlap: observed hi_a=%b lo_a=%b hi_b=%b lo_b=%b expected no same-leg overlap",
               hi_a, lo_a, hi_b, lo_b);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    wr_n     = 1'b1;
    addr     = 1'b0;
    wrdata   = 32'd0;
    pwm_in   = 1'b0;
    dir_in   = 1'b0;
    fault_in = 1'b0;

    // Reset state
    expect_run(2, "reset_state", ALL_OFF);
    reset = 1'b0;
    expect_step("idle_disabled", ALL_OFF);

    // Enable with dir=0, pwm=0: both legs reach LO after 1+20 cycles
    reg_write(ADDR_CTRL, 32'h1, "enable_write", ALL_OFF);
    expect_run(20, "startup_dead", ALL_OFF);
    expect_step("startup_lo", LO_LO);

    // dt=5 rising and falling PWM edges on leg A
    reg_write(ADDR_DT, 32'd5, "dt5_write", LO_LO);
    pwm_in = 1'b1;
    expect_step("rise_edgeN", LO_LO);
    expect_run(5, "rise_dead", DEADA_LOB);
    expect_step("rise_hi_on", HIA_LOB);
    expect_run(2, "hi_hold", HIA_LOB);
    pwm_in = 1'b0;
    expect_step("fall_edgeM", HIA_LOB);
    expect_run(5, "fall_dead", DEADA_LOB);
    expect_step("fall_lo_on", LO_LO);

    // dt=10, 4-cycle pulse is swallowed; lo_a low for exactly 10 cycles
    reg_write(ADDR_DT, 32'd10, "dt10_write", LO_LO);
    pwm_in = 1'b1;
    expect_step("pulse_edgeN", LO_LO);
    expect_run(3, "pulse_dead_hi_req", DEADA_LOB);
    pwm_in = 1'b0;
    expect_run(7, "pulse_dead_lo_req", DEADA_LOB);
    expect_step("pulse_back_lo", LO_LO);

    // dt=3, direction change while pwm=1
    reg_write(ADDR_DT, 32'd3, "dt3_write", LO_LO);
    pwm_in = 1'b1;
    expect_step("dir0_edge", LO_LO);
    expect_run(3, "dir0_dead", DEADA_LOB);
    expect_step("dir0_hi", HIA_LOB);
    expect_run(2, "dir0_hold", HIA_LOB);
    dir_in = 1'b1;
    expect_step("dir1_edge", HIA_LOB);
    expect_run(3, "dir1_both_dead", ALL_OFF);
    expect_step("dir1_swapped", LOA_HIB);
    expect_run(2, "dir1_hold", LOA_HIB);

    // One-cycle fault pulse mid-HI on leg B
    fault_in = 1'b1;
    expect_step("fault_edgeF", LOA_HIB);
    fault_in = 1'b0;
    expect_step("fault_F1", LOA_HIB);
    expect_step("fault_flag_F2", FLT_RUN);
    expect_step("fault_gates_off_F3", FLT_OFF);
    expect_run(3, "fault_sticky", FLT_OFF);

    // Clear while the fault input is still high is ignored
    fault_in = 1'b1;
    expect_run(3, "fault_reasserted", FLT_OFF);
    reg_write(ADDR_CTRL, 32'h3, "clr_while_fault_write", FLT_OFF);
    expect_run(3, "clr_ignored", FLT_OFF);
    fault_in = 1'b0;
    expect_run(3, "fault_input_low", FLT_OFF);

    // Valid clear: flag drops at C+1, legs restart through DEAD
    reg_write(ADDR_CTRL, 32'h3, "clr_write", FLT_OFF);
    expect_step("clr_flag_drop", ALL_OFF);
    expect_run(3, "restart_dead", ALL_OFF);
    expect_step("restart_on", LOA_HIB);

    // dt write of 0 becomes a 1-cycle dead interval (leg B HI->LO)
    reg_write(ADDR_DT, 32'd0, "dt0_write", LOA_HIB);
    pwm_in = 1'b0;
    expect_step("dt0_edge", LOA_HIB);
    expect_step("dt0_dead_one", LOA_DEADB);
    expect_step("dt0_lo_on", LO_LO);

    // Async reset in the middle of a DEAD interval
    reg_write(ADDR_DT, 32'd8, "dt8_write", LO_LO);
    pwm_in = 1'b1;
    expect_step("mid_dead_edge", LO_LO);
    expect_run(2, "mid_dead", LOA_DEADB);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", gates(), ALL_OFF);
    expect_run(2, "reset_hold", ALL_OFF);
    pwm_in = 1'b0;
    dir_in = 1'b0;
    reset  = 1'b0;

    // dt must be back at 20 after reset
    reg_write(ADDR_CTRL, 32'h1, "reenable_write", ALL_OFF);
    expect_run(20, "dt_restored_dead", ALL_OFF);
    expect_step("dt_restored_lo", LO_LO);
    expect_run(2, "final_hold", LO_LO);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hbridge_deadtime.md
# hbridge_deadtime

Gate-drive stage placed directly downstream of the motor PWM generator. It consumes the generator's `pwm` and `dir_out` signals and produces the four H-bridge gate signals. It enforces a programmable dead time on every leg transition and guarantees that no leg ever has its high and low switch on together. It also latches an external over-current fault that forces every gate off until software clears it.

## Interface
Parameters:
- `DT_RESET`, default 8'd20: dead-time value loaded at reset, in clk cycles.
- `DT_W`, default 8: dead-time register and counter width.

Ports:
- `clk`  in  1  system clock; all logic in this one domain.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_n`  in  1  active-low register write strobe, sampled on `clk`.
- `addr`  in  1  register select: 0 selects dead time, 1 selects control.
- `wrdata`  in  32  write data.
- `pwm_in`  in  1  PWM from the upstream generator, same clock domain.
- `dir_in`  in  1  direction from the upstream generator: 0 drives leg A, 1 drives leg B.
- `fault_in`  in  1  asynchronous over-current comparator output, active-high.
- `hi_a`, `lo_a`, `hi_b`, `lo_b`  out  1 each  gate enables, active-high, registered.
- `fault_flag`  out  1  latched fault status.

## Operation
- Registers:
  - addr 0 writes `dt <= wrdata[DT_W-1:0]`. A written value of 0 is stored as 1.
  - addr 1, bit0 writes `enable`.
  - addr 1, bit1 = 1 is a fault-clear request. It takes effect only if synchronized `fault_in` is 0; otherwise it is ignored.
- Input stage:
  - `pwm_in` and `dir_in` are registered once (`pwm_q`, `dir_q`).
  - `fault_in` passes through a 2-flop synchronizer.
- Leg requests (each leg requests OFF, HI or LO):
  - When `enable`=0 or `fault_flag`=1, both legs request OFF.
  - Otherwise the active leg (A if `dir_q`=0, else B) requests HI when `pwm_q`=1 and LO when `pwm_q`=0.
  - The passive leg requests LO (slow-decay braking path).
- Leg FSM (one instance per leg), states OFF, HI, LO, DEAD:
  - OFF, with request HI or LO: go to DEAD and latch the target.
  - HI with request LO, or LO with request HI: go to DEAD.
  - Any state with request OFF: go to OFF immediately, because switching off needs no dead time.
  - DEAD: the counter loads `dt` on entry and decrements each cycle. On the cycle it reaches 1, the FSM enters the then-current request. If that request is OFF, the FSM goes to OFF.
  - In HI, `hi`=1 and `lo`=0. In LO, `lo`=1 and `hi`=0. In OFF and DEAD, both are 0.
- Writes to `dt` take effect at the next DEAD entry and never alter a running count.
- Fault handling:
  - Synchronized `fault_in`=1 sets `fault_flag` and forces both legs to OFF.
  - The flag stays set until a valid clear is written.
  - On clear, the legs restart through DEAD; no leg ever enters HI or LO directly from OFF.
- Direction change while running: each leg resolves independently through its own DEAD. The bridge never produces a same-leg HI/LO overlap.

## Timing
- Reset values: all gate outputs 0, `fault_flag` 0, `enable` 0, `dt`=`DT_RESET`, both FSMs in OFF, counters 0.
- PWM edge to gate-off: `pwm_in` changes before edge N; the conducting switch turns off at edge N+1.
- Gate-off to gate-on: the opposite switch turns on at edge N+1+dt, so both switches are off for exactly `dt` cycles.
- Pulses on `pwm_q` shorter than `dt`: the request reverts during DEAD, so the FSM returns to the original switch after `dt` cycles and the short pulse is never driven.
- Fault latency: `fault_in` rising before edge F sets `fault_flag` at edge F+2 and drives all gates to 0 at edge F+3.
- Clear latency: a clear written at edge C drops `fault_flag` at C+1.
- Simultaneous fault and clear in the same cycle: the fault wins.
- Invariant, checked every cycle: `hi_a & lo_a` = 0 and `hi_b & lo_b` = 0.

## Structure
- Shared package contents:
  - leg state enum (OFF, HI, LO, DEAD);
  - leg request encoding;
  - register address constants `ADDR_DT`=0 and `ADDR_CTRL`=1;
  - control bit indices `CTRL_EN`=0 and `CTRL_CLR`=1.
- Sub-module `leg_deadtime`: ports are clk, reset, req, dt, hi, lo. It holds the FSM and counter and is instantiated twice. The top level holds the registers, the synchronizer, fault latch and request mapping.

## Test plan
- Reset with `DT_RESET`=20, then write enable=1, `dir_in`=0, `pwm_in`=0 -> `lo_a`=1 and `lo_b`=1 after 1+20 cycles; `hi_a`=`hi_b`=0 throughout.
- dt=5, `pwm_in` rises at edge N -> `lo_a` falls at N+1 and `hi_a` rises at N+6. `pwm_in` falls at M -> `hi_a` falls at M+1 and `lo_a` rises at M+6.
- dt=10, a 4-cycle `pwm_in` pulse -> `hi_a` never asserts, and `lo_a` is low for exactly 10 cycles.
- Toggle `dir_in` 0→1 with `pwm_in`=1, dt=3 -> `hi_a` falls and `lo_a` rises 3 cycles later; `lo_b` falls and `hi_b` rises 3 cycles later. The invariant holds throughout.
- Pulse `fault_in` for 1 cycle mid-HI -> gates go to 0 at F+3 and `fault_flag` stays 1. A clear written while `fault_in`=1 is ignored; a clear after `fault_in`=0 resumes operation through DEAD.
- Write dt=0 -> the dead interval is 1 cycle. Assert reset mid-DEAD -> all outputs 0 immediately and dt returns to 20.
